dsi_pkt_assembler: RTL

//  Downstream stage of the DSI ECC generator. Merges a packet header (DI, WC), the ECC

---
 rtl/dsi_pkt_if.sv | 31 +++
 rtl/dsi_pkt_assembler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dsi_pkt_if.sv
// Byte-stream bundle between the DSI header/ECC/payload sources, the packet assembler
// and the lane distributor.
interface dsi_pkt_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic [7:0]  ecc;
    logic        ecc_done;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;

    // Source side: header/ECC/payload producers and the downstream sink.
    modport master (
        output hdr_valid, hdr_di, hdr_wc, hdr_long, ecc, ecc_done, pl_valid, pl_data, out_ready,
        input  hdr_ready, pl_ready, out_valid, out_data, out_sop, out_eop
    );

    // Assembler side.
    modport slave (
        input  hdr_valid, hdr_di, hdr_wc, hdr_long, ecc, ecc_done, pl_valid, pl_data, out_ready,
        output hdr_ready, pl_ready, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/dsi_pkt_assembler.sv
// DSI packet assembler: merges header, ECC and payload into one byte stream and appends
// the reflected CRC-16 to long packets.
module dsi_pkt_assembler #(
    parameter int unsigned ECC_TIMEOUT = 64,
    parameter logic [15:0] CRC_SEED    = 16'hFFFF
) (
    input  logic     dsi_clk,
    input  logic     dsi_rst,
    dsi_pkt_if.slave bus,
    output logic     ecc_timeout_err,
    output logic     busy
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitEcc,
        StHdr,
        StPayload,
        StCrcLo,
        StCrcHi
    } state_e;

    state_e      state_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic        long_q;
    logic [7:0]  ecc_q;
    logic        ecc_pend_q;
    logic [1:0]  idx_q;
    logic [15:0] rem_q;
    logic [31:0] cnt_q;
    logic [15:0] crc_q;
    logic        err_q;
    logic        xfer;

    // One byte of reflected CCITT (poly 0x8408), LSB first, no final XOR.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        bus.hdr_ready = (state_q == StIdle);
        bus.pl_ready  = (state_q == StPayload) && bus.out_ready;
        bus.out_valid = 1'b0;
        bus.out_data  = 8'h00;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        unique case (state_q)
            StHdr: begin
                bus.out_valid = 1'b1;
                case (idx_q)
                    2'd0: begin
                        bus.out_data = di_q;
                        bus.out_sop  = 1'b1;
                    end
                    2'd1: bus.out_data = wc_q[7:0];
                    2'd2: bus.out_data = wc_q[15:8];
                    default: begin
                        bus.out_data = ecc_q;
                        bus.out_eop  = !long_q;
                    end
                endcase
            end
            // Payload passes straight through so there is no added latency or bubble.
            StPayload: begin
                bus.out_valid = bus.pl_valid;
                bus.out_data  = bus.pl_data;
            end
            StCrcLo: begin
                bus.out_valid = 1'b1;
                bus.out_data  = crc_q[7:0];
            end
            StCrcHi: begin
                bus.out_valid = 1'b1;
                bus.out_data  = crc_q[15:8];
                bus.out_eop   = 1'b1;
            end
            default: ;
        endcase
    end

    assign xfer            = bus.out_valid && bus.out_ready;
    assign busy            = (state_q != StIdle);
    assign ecc_timeout_err = err_q;

    always_ff @(posedge dsi_clk) begin
        if (dsi_rst) begin
            state_q    <= StIdle;
            di_q       <= 8'h00;
            wc_q       <= 16'h0000;
            long_q     <= 1'b0;
            ecc_q      <= 8'h00;
            ecc_pend_q <= 1'b0;
            idx_q      <= 2'd0;
            rem_q      <= 16'h0000;
            cnt_q      <= 32'd0;
            crc_q      <= CRC_SEED;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.ecc_done && (state_q == StIdle || state_q == StWaitEcc)) begin
                ecc_q      <= bus.ecc;
                ecc_pend_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (bus.hdr_valid) begin
                        di_q   <= bus.hdr_di;
                        wc_q   <= bus.hdr_wc;
                        long_q <= bus.hdr_long;
                        rem_q  <= bus.hdr_wc;
                        cnt_q  <= 32'd0;
                        crc_q  <= CRC_SEED;
                        idx_q  <= 2'd0;
                        // The pending ECC belongs to this header, so consume it now.
                        if (ecc_pend_q || bus.ecc_done) begin
                            state_q    <= StHdr;
                            ecc_pend_q <= 1'b0;
                        end else begin
                            state_q <= StWaitEcc;
                        end
                    end
                end
                StWaitEcc: begin
                    if (ecc_pend_q || bus.ecc_done) begin
                        state_q    <= StHdr;
                        ecc_pend_q <= 1'b0;
                    end else if (ECC_TIMEOUT != 0 && cnt_q == ECC_TIMEOUT - 1) begin
                        state_q    <= StIdle;
                        ecc_pend_q <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        if (idx_q == 2'd3) begin
                            if (!long_q) begin
                                state_q <= StIdle;
                            end else if (wc_q == 16'h0000) begin
                                state_q <= StCrcLo;
                            end else begin
                                state_q <= StPayload;
                            end
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                StPayload: begin
                    if (xfer) begin
                        crc_q <= crc_byte(crc_q, bus.pl_data);
                        rem_q <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= StCrcLo;
                        end
                    end
                end
                StCrcLo: begin
                    if (xfer) begin
                        state_q <= StCrcHi;
                    end
                end
                StCrcHi: begin
                    if (xfer) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
